// File: rtl/led_blink_sched.sv
// Round-robin scheduler that shares one status LED among NREQ requesters.
// A grant plays a burst of ON/OFF blinks for the winner, then a dark gap.
module led_blink_sched #(
  parameter int NREQ       = 4,
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 25000000,
  parameter int GAP_CYCLES = 50000000,
  parameter int TMR_W      = 27,
  localparam int ID_W      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_count,
  input  logic              abort,
  output logic              led,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [ID_W-1:0]   active_id
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(NREQ - 1);

  logic [1:0]      state_r, state_s;
  logic [TMR_W-1:0] timer_r, timer_s;
  logic [3:0]      remaining_r, remaining_s;
  logic [ID_W-1:0] ptr_r, ptr_s;
  logic            led_r, led_s;
  logic [NREQ-1:0] gnt_r, gnt_s;
  logic [NREQ-1:0] done_r, done_s;
  logic            busy_r, busy_s;
  logic [ID_W-1:0] active_id_r, active_id_s;

  logic            found_s;
  logic [ID_W-1:0] pick_s;
  logic [3:0]      pick_count_s;
  logic [3:0]      rem_dec_s;

  // Round-robin search: first set req bit upward from ptr+1, wrapping.
  always_comb begin
    int idx;
    found_s = 1'b0;
    pick_s  = '0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_r) + k >= NREQ) ? int'(ptr_r) + k - NREQ : int'(ptr_r) + k;
      if (!found_s && req[idx[ID_W-1:0]]) begin
        found_s = 1'b1;
        pick_s  = idx[ID_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
    pick_count_s = req_count[{pick_s, 2'b00} +: 4];
    rem_dec_s    = remaining_r - 4'd1;
  end

  // Next-state logic; abort outside IDLE overrides any phase end.
  always_comb begin
    state_s     = state_r;
    timer_s     = timer_r + TMR_W'(1);
    remaining_s = remaining_r;
    ptr_s       = ptr_r;
    led_s       = led_r;
    gnt_s       = '0;
    done_s      = '0;
    busy_s      = busy_r;
    active_id_s = active_id_r;
    if (abort && (state_r != ST_IDLE)) begin
      state_s = ST_IDLE;
      timer_s = '0;
      led_s   = 1'b0;
      busy_s  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          timer_s = '0;
          led_s   = 1'b0;
          busy_s  = 1'b0;
          if (found_s) begin
            gnt_s       = ONE_HOT0 << pick_s;
            active_id_s = pick_s;
            ptr_s       = pick_s;
            remaining_s = pick_count_s;
            busy_s      = 1'b1;
            if (pick_count_s != 4'd0) begin
              state_s = ST_ON;
              led_s   = 1'b1;
            end else begin
              state_s = ST_GAP;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ON: begin
          if (timer_r == ON_LAST) begin
            timer_s     = '0;
            remaining_s = rem_dec_s;
            led_s       = 1'b0;
            state_s     = (rem_dec_s != 4'd0) ? ST_OFF : ST_GAP;
          end else begin
            led_s = 1'b1;
          end
        end
        ST_OFF: begin
          if (timer_r == OFF_LAST) begin
            timer_s = '0;
            led_s   = 1'b1;
            state_s = ST_ON;
          end else begin
            led_s = 1'b0;
          end
        end
        ST_GAP: begin
          led_s = 1'b0;
          if (timer_r == GAP_LAST) begin
            timer_s = '0;
            done_s  = ONE_HOT0 << active_id_r;
            busy_s  = 1'b0;
            state_s = ST_IDLE;
          end else begin
            busy_s = 1'b1;
          end
        end
        default: begin
          state_s = ST_IDLE;
          timer_s = '0;
          led_s   = 1'b0;
          busy_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      timer_r     <= '0;
      remaining_r <= 4'd0;
      ptr_r       <= PTR_INIT;
      led_r       <= 1'b0;
      gnt_r       <= '0;
      done_r      <= '0;
      busy_r      <= 1'b0;
      active_id_r <= '0;
    end else begin
      state_r     <= state_s;
      timer_r     <= timer_s;
      remaining_r <= remaining_s;
      ptr_r       <= ptr_s;
      led_r       <= led_s;
      gnt_r       <= gnt_s;
      done_r      <= done_s;
      busy_r      <= busy_s;
      active_id_r <= active_id_s;
    end
  end

  assign led       = led_r;
  assign gnt       = gnt_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign active_id = active_id_r;

endmodule

// File: tb/tb_led_blink_sched.sv
// Bench for led_blink_sched: directed scenarios plus random traffic, all checked
// against a burst-offset model (grant cycle = offset 0 of an arithmetic schedule).
module tb_led_blink_sched;

  localparam int NREQ  = 4;
  localparam int ON    = 4;
  localparam int OFF   = 2;
  localparam int GAP   = 6;
  localparam int TMR_W = 4;
  localparam int OW    = 2 + 2 * NREQ + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_count;
  logic              abort;
  logic              led;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [1:0]        active_id;

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] want;
  int glog[$];

  // model: state describing the current cycle
  bit m_busy, m_gnt, m_done;
  int m_t, m_len, m_cnt, m_id, m_ptr;

  led_blink_sched #(
    .NREQ(NREQ), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .GAP_CYCLES(GAP), .TMR_W(TMR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_count(req_count), .abort(abort),
    .led(led), .gnt(gnt), .done(done), .busy(busy), .active_id(active_id)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 0; m_gnt = 0; m_done = 0;
    m_t = 0; m_len = 0; m_cnt = 0; m_id = 0; m_ptr = NREQ - 1;
  endtask

  // Expected {led,busy,gnt,done,active_id} for the current cycle.
  function automatic logic [OW-1:0] model_out();
    int lit;
    logic l;
    logic [NREQ-1:0] oh;
    lit = (m_cnt == 0) ? 0 : m_cnt * ON + (m_cnt - 1) * OFF;
    l   = m_busy && (m_t < lit) && ((m_t % (ON + OFF)) < ON);
    oh  = {{(NREQ-1){1'b0}}, 1'b1} << m_id;
    model_out = {l, m_busy, (m_gnt ? oh : 4'b0000), (m_done ? oh : 4'b0000), 2'(m_id)};
  endfunction

  // Advance the model across one clock edge using the inputs now applied.
  task automatic advance();
    if (gnt != 4'b0000) glog.push_back(int'(active_id));
    if (m_busy) begin
      m_gnt = 0;
      if (abort) begin
        m_busy = 0; m_done = 0;
      end else if (m_t == m_len - 1) begin
        m_busy = 0; m_done = 1;
      end else begin
        m_t++; m_done = 0;
      end
    end else begin
      m_done = 0; m_gnt = 0;
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (!m_gnt && req[i[1:0]]) begin
          m_gnt = 1; m_busy = 1; m_t = 0; m_id = i; m_ptr = i;
          m_cnt = int'(req_count[{i[1:0], 2'b00} +: 4]);
          m_len = (m_cnt == 0) ? GAP : m_cnt * ON + (m_cnt - 1) * OFF + GAP;
        end
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({led, busy, gnt, done} !== 10'b0) begin
        errors++;
        $display("FAIL reset_hold got %b want %b", {led, busy, gnt, done}, 10'b0);
      end
    end
    rst_n = 1'b1;
    advance();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      want = model_out();
      checks++;
      if ({led, busy, gnt, done, active_id} !== want) begin
        errors++;
        $display("FAIL reset_idle c=%0d got %b want %b", c, {led, busy, gnt, done, active_id}, want);
      end
      advance();
    end
  endtask

  task automatic test_burst();
    int bcnt = 0;
    int dcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      want = model_out();
      checks++;
      if ({led, busy, gnt, done, active_id} !== want) begin
        errors++;
        $display("FAIL burst c=%0d got %b want %b", c, {led, busy, gnt, done, active_id}, want);
      end
      if (busy) bcnt++;
      if (done == 4'b0010) dcnt++;
      req       = (c == 0) ? 4'b0010 : 4'b0000;
      req_count = 16'h0030;
      advance();
    end
    checks++;
    if (bcnt !== 22 || dcnt !== 1) begin
      errors++;
      $display("FAIL burst_len busy=%0d done=%0d want 22 and 1", bcnt, dcnt);
    end
  endtask

  task automatic test_rr();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    req       = 4'b0101;
    req_count = 16'h1111;
    glog.delete();
    advance();
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      want = model_out();
      checks++;
      if ({led, busy, gnt, done, active_id} !== want) begin
        errors++;
        $display("FAIL rr c=%0d got %b want %b", c, {led, busy, gnt, done, active_id}, want);
      end
      if (c == 30) req = 4'b1001;
      else req = req & ~gnt;
      advance();
    end
    checks++;
    if (glog.size() != 4 || glog[0] != 0 || glog[1] != 2 || glog[2] != 3 || glog[3] != 0) begin
      errors++;
      $display("FAIL rr_order got %p want '{0,2,3,0}", glog);
    end
  endtask

  task automatic test_zero();
    int gc = -100;
    int dc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      want = model_out();
      checks++;
      if ({led, busy, gnt, done, active_id} !== want) begin
        errors++;
        $display("FAIL zero c=%0d got %b want %b", c, {led, busy, gnt, done, active_id}, want);
      end
      if (gnt == 4'b0100) gc = c;
      if (done == 4'b0100) dc = c;
      req       = (c == 0) ? 4'b0100 : 4'b0000;
      req_count = 16'h0000;
      advance();
    end
    checks++;
    if (dc - gc !== 6) begin
      errors++;
      $display("FAIL zero_gap done-gnt=%0d want 6", dc - gc);
    end
  endtask

  task automatic test_abort();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      want = model_out();
      checks++;
      if ({led, busy, gnt, done, active_id} !== want) begin
        errors++;
        $display("FAIL abort c=%0d got %b want %b", c, {led, busy, gnt, done, active_id}, want);
      end
      if (c == 3) begin
        checks++;
        if ({led, busy, done} !== 6'b0) begin
          errors++;
          $display("FAIL abort_stop got %b want %b", {led, busy, done}, 6'b0);
        end
      end
      if (c == 4) begin
        checks++;
        if (gnt !== 4'b0010) begin
          errors++;
          $display("FAIL abort_next_gnt got %b want %b", gnt, 4'b0010);
        end
      end
      req       = (c == 0) ? 4'b0001 : ((c < 4) ? 4'b0010 : 4'b0000);
      req_count = 16'h0012;
      abort     = (c == 2);
      advance();
    end
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      want = model_out();
      checks++;
      if ({led, busy, gnt, done, active_id} !== want) begin
        errors++;
        $display("FAIL rmid c=%0d got %b want %b", c, {led, busy, gnt, done, active_id}, want);
      end
      if (c < 5) begin
        req       = (c == 0) ? 4'b0100 : 4'b0000;
        req_count = 16'h0200;
        advance();
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({led, busy, active_id} !== 4'b0) begin
      errors++;
      $display("FAIL rmid_async got %b want %b", {led, busy, active_id}, 4'b0);
    end
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    req       = 4'b1001;
    req_count = 16'h1001;
    glog.delete();
    advance();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      want = model_out();
      checks++;
      if ({led, busy, gnt, done, active_id} !== want) begin
        errors++;
        $display("FAIL rmid_after c=%0d got %b want %b", c, {led, busy, gnt, done, active_id}, want);
      end
      req = req & ~gnt;
      advance();
    end
    checks++;
    if (glog.size() == 0 || glog[0] != 0) begin
      errors++;
      $display("FAIL rmid_first got %p want first 0", glog);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      want = model_out();
      checks++;
      if ({led, busy, gnt, done, active_id} !== want) begin
        errors++;
        $display("FAIL random c=%0d got %b want %b", c, {led, busy, gnt, done, active_id}, want);
      end
      req       = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      req_count = 16'($urandom) & 16'h3333;
      abort     = ($urandom_range(0, 24) == 0);
      advance();
    end
    abort = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 4'b0000;
    req_count = 16'h0000;
    abort     = 1'b0;
    test_reset();
    test_burst();
    test_rr();
    test_zero();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
